// File: rtl/romulus_pkg.sv
// Shared constants, FSM encoding and lane-mask helper for the Romulus
// 32-bit pad/sequencer.
package romulus_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int BLOCK_BYTES = 16;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bytes are MSB-aligned, so lane 3 (bdi[31:24]) is the first valid byte.
  function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [2:0] nbytes);
    lane_mask[3] = (nbytes >= 3'd1);
    lane_mask[2] = (nbytes >= 3'd2);
    lane_mask[1] = (nbytes >= 3'd3);
    lane_mask[0] = (nbytes >= 3'd4);
  endfunction

endpackage

// File: rtl/romulus_pad_word.sv
// Per-word formatting: zeroes invalid byte lanes on pdi/bdo, optionally
// drops the block length into the low byte, and builds the decrypt mask.
module romulus_pad_word
  import romulus_pkg::*;
(
  input  logic [31:0] bdi_i,
  input  logic [2:0]  valid_bytes_i,
  input  logic [31:0] pdo_i,
  input  logic        dec_i,
  input  logic        len_en_i,
  input  logic [7:0]  len_byte_i,
  output logic [31:0] pdi_o,
  output logic [31:0] bdo_o,
  output logic [3:0]  decrypt_o
);

  logic [3:0]  lanes;
  logic [31:0] byte_mask;

  assign lanes     = lane_mask(valid_bytes_i);
  assign byte_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign decrypt_o = {4{dec_i}} & lanes;
  assign bdo_o     = pdo_i & byte_mask;

  // Length insertion only happens when lane 0 is invalid, so it never
  // overwrites a data byte.
  always_comb begin
    pdi_o = bdi_i & byte_mask;
    if (len_en_i) pdi_o[7:0] = len_byte_i;
  end

endmodule

// File: rtl/romulus_pad_32b.sv
// Block sequencer ahead of the 32-bit Romulus state update: feeds four pdi
// words per block, inserts padding, and returns pdo as bdo.
module romulus_pad_32b
  import romulus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_start,
  input  logic        blk_empty,
  input  logic        out_en,
  input  logic        dec,
  input  logic [31:0] bdi,
  input  logic        bdi_valid,
  output logic        bdi_ready,
  input  logic [2:0]  bdi_valid_bytes,
  input  logic        bdi_last,
  output logic [31:0] pdi,
  output logic [3:0]  decrypt,
  output logic        se,
  input  logic [31:0] pdo,
  output logic [31:0] bdo,
  output logic        bdo_valid,
  input  logic        bdo_ready,
  output logic [2:0]  bdo_valid_bytes,
  output logic        blk_done,
  output logic        blk_partial
);

  localparam logic [1:0] LAST_WORD  = 2'(BLOCK_WORDS - 1);
  localparam logic [4:0] FULL_BYTES = 5'(BLOCK_BYTES);

  state_e     state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [4:0] bcnt_q, bcnt_d;
  logic       out_en_q, out_en_d;
  logic       dec_q, dec_d;
  logic       partial_q, partial_d;

  logic [4:0]  byte_sum;
  logic        len_en;
  logic        xfer;
  logic [31:0] word_pdi;
  logic [31:0] word_bdo;
  logic [3:0]  word_dec;

  assign byte_sum = bcnt_q + {2'b00, bdi_valid_bytes};
  assign len_en   = (wcnt_q == LAST_WORD) && bdi_last && (byte_sum < FULL_BYTES);

  romulus_pad_word u_word (
    .bdi_i         (bdi),
    .valid_bytes_i (bdi_valid_bytes),
    .pdo_i         (pdo),
    .dec_i         (dec_q),
    .len_en_i      (len_en),
    .len_byte_i    ({3'b000, byte_sum}),
    .pdi_o         (word_pdi),
    .bdo_o         (word_bdo),
    .decrypt_o     (word_dec)
  );

  assign bdo_valid_bytes = bdi_valid_bytes;
  assign blk_partial     = partial_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value; the combinational block below uses blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      out_en_q  <= 1'b0;
      dec_q     <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      out_en_q  <= out_en_d;
      dec_q     <= dec_d;
      partial_q <= partial_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    out_en_d  = out_en_q;
    dec_d     = dec_q;
    partial_d = partial_q;
    xfer      = 1'b0;
    se        = 1'b0;
    bdi_ready = 1'b0;
    bdo_valid = 1'b0;
    bdo       = '0;
    pdi       = '0;
    decrypt   = '0;
    blk_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (blk_start) begin
          out_en_d  = out_en;
          dec_d     = dec;
          wcnt_d    = '0;
          bcnt_d    = '0;
          partial_d = blk_empty;
          state_d   = blk_empty ? ST_PAD : ST_FEED;
        end
      end

      ST_FEED: begin
        bdi_ready = !out_en_q || bdo_ready;
        xfer      = bdi_valid && bdi_ready;
        bdo_valid = out_en_q && bdi_valid;
        se        = xfer;
        pdi       = word_pdi;
        decrypt   = word_dec;
        bdo       = word_bdo;
        if (xfer) begin
          wcnt_d = wcnt_q + 2'd1;
          bcnt_d = byte_sum;
          if (len_en) partial_d = 1'b1;
          if (wcnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end else if (bdi_last) begin
            partial_d = 1'b1;
            state_d   = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        se     = 1'b1;
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == LAST_WORD) begin
          pdi     = {27'd0, bcnt_q};
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        blk_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/romulus_pad_32b.md
# romulus_pad_32b

Block-level input/output sequencer placed directly upstream of the 32-bit Romulus state update datapath. It accepts 32-bit words from the public-data stream and drives the state update with four `pdi` words per 128-bit block, along with the per-byte `decrypt` mask and the `se` shift enable. It inserts Romulus padding for partial or empty final blocks and forwards the `pdo` words back out as `bdo` with a valid/ready handshake.

## Interface
Parameters:
- none. Block size is fixed at 4 words × 4 bytes. Constants live in the package.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `blk_start` in 1: one-cycle pulse that starts one 128-bit block. Ignored unless the FSM is in IDLE.
- `blk_empty` in 1: sampled with `blk_start`. The block carries 0 data bytes.
- `out_en` in 1: sampled with `blk_start`. The block produces `bdo` (message phase); when 0, the block absorbs only (AD phase).
- `dec` in 1: sampled with `blk_start`. Decryption mode.
- `bdi` in 32: input word. `bdi[31:24]` is the first byte.
- `bdi_valid` in 1, `bdi_ready` out 1: input handshake.
- `bdi_valid_bytes` in 3: number of valid bytes in this word, 1..4. Bytes are MSB-aligned.
- `bdi_last` in 1: this word ends the data.
- `pdi` out 32: word to the state update.
- `decrypt` out 4: per-byte select toward the state update. Bit 3 maps to `pdi[31:24]`.
- `se` out 1: shift enable to the state update, one pulse per word.
- `pdo` in 32: keystream-combined word from the state update.
- `bdo` out 32, `bdo_valid` out 1, `bdo_ready` in 1: output handshake.
- `bdo_valid_bytes` out 3: copy of `bdi_valid_bytes` for the accepted word.
- `blk_done` out 1: one-cycle pulse after the 4th `se`.
- `blk_partial` out 1: the last block held fewer than 16 bytes. Held until the next `blk_start`.

## Operation
- **FSM states:** IDLE, FEED, PAD, DONE.
- **IDLE:**
  - `blk_start` latches `out_en`, `dec` and `blk_empty`, clears `wcnt` (2 bits), `bcnt` (5 bits) and `blk_partial`.
  - Next state is PAD if `blk_empty`, otherwise FEED.
- **FEED:**
  - Transfer condition: `xfer = bdi_valid & (!out_en | bdo_ready)`.
  - `bdi_ready = !out_en | bdo_ready`.
  - `bdo_valid = out_en & bdi_valid`.
  - `se = xfer`.
  - On `xfer`: `wcnt += 1` and `bcnt += bdi_valid_bytes`.
  - On `xfer` with `wcnt==3`: go to DONE.
  - On `xfer` with `bdi_last` and `wcnt<3`: go to PAD.
- **Word formation (FEED):**
  - `pdi` takes `bdi` valid bytes; invalid byte lanes are 0x00.
  - If this word is the 4th word, `bdi_last` is set and `bcnt+valid_bytes<16`, `pdi[7:0]` is forced to that byte count and `blk_partial` is set. A 4th word has at most 3 valid bytes in this case.
  - `decrypt[i] = dec & lane i valid`.
- **PAD:**
  - `bdi_ready=0`, `bdo_valid=0`.
  - `se=1` every cycle. `pdi` = 0, except that the word with `wcnt==3` carries `pdi[7:0]=bcnt`.
  - `decrypt=0`.
  - `blk_partial=1`.
  - After the `wcnt==3` word, go to DONE.
- **DONE:** `blk_done=1` for one cycle, then IDLE.
- **Output path:**
  - `bdo = pdo` with invalid lanes zeroed.
  - `bdo_valid_bytes = bdi_valid_bytes`.
- **Full block with `bdi_last` on word 4:** no padding and `blk_partial=0`.

## Timing
- `pdi`, `decrypt`, `se`, `bdi_ready`, `bdo`, `bdo_valid` are combinational from registered state and handshake inputs. There is zero latency from `bdi` to `pdi` to `bdo`.
- The state update captures on the same edge as `xfer`.
- Exactly 4 `se` pulses per block.
- Block cycles = (number of FEED stall cycles + 4) + 1 DONE cycle.
- **Reset values:**
  - FSM in IDLE; all counters 0.
  - `se=0`, `bdi_ready=0`, `bdo_valid=0`, `blk_done=0`, `blk_partial=0`, `pdi=0`, `decrypt=0`.
- **Reset mid-block:** immediate return to IDLE. A partially shifted state is the controller's responsibility.
- **Handshake rules:**
  - `blk_start` during FEED, PAD or DONE is ignored.
  - `bdo_ready` low with `out_en=1` stalls input; `se` stays low.
  - `bdo_valid` never depends on `bdo_ready`.
- `bdi_valid_bytes<4` without `bdi_last` is illegal. Bench assertion only.

## Structure
- **Package `romulus_pkg`:**
  - FSM state enum.
  - `BLOCK_WORDS=4`, `BLOCK_BYTES=16`, `WORD_BYTES=4`.
- **Sub-module `romulus_pad_word`:** combinational per-word lane masking, length-byte insertion and `decrypt` mask generation. Instantiated once.

## Test plan
- **Full AD block:** `out_en=0`, 4 words `0x00010203..0x0C0D0E0F`, `bdi_valid` always high → 4 consecutive `se`, `pdi` equals `bdi`, no `bdo_valid`, `blk_done` on cycle 5, `blk_partial=0`.
- **Partial message:** `out_en=1`, `dec=0`, words `0xAABBCCDD` then `0x11220000` (`valid_bytes=2`, `last`) → `pdi` = `0xAABBCCDD`, `0x11220000`, `0x00000000`, `0x00000006`; exactly 2 `bdo` beats; `blk_partial=1`.
- **Empty block:** `blk_start` with `blk_empty=1` → 4 PAD `se` pulses, last `pdi=0x00000000`, `decrypt=0`, `blk_partial=1`.
- **Decrypt with backpressure:** `dec=1`, `bdo_ready` toggling 1/0 → `se` only when `bdo_ready=1`, `decrypt=4'hF` on full words, `bdo` matches `pdo`, 4 `se` total.
- **Reset mid-block:** assert `rst` low after 2 `se` → all outputs 0 asynchronously; a new `blk_start` then runs a clean 4-word block.
- **Ignored start:** `blk_start` pulsed during FEED → no counter reset, exactly 4 `se`, a single `blk_done`.
